// File: rtl/nios_system_mem_pkg.sv
// nios_system_mem_pkg: shared constants and types for the main-memory arbiter
package nios_system_mem_pkg;
  localparam int MEM_ADDR_W = 17;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_DEPTH  = 76800;
  localparam int MAX_BURST  = 16;
  localparam int BURST_W    = 5;
  typedef enum logic [1:0] {IDLE = 2'd0, RD_BURST = 2'd1, WR_BURST = 2'd2} state_t;
  typedef enum logic {PORT_CPU = 1'b0, PORT_DMA = 1'b1} port_t;
  // zero-length bursts mean one beat; oversize bursts are cut to the maximum
  function automatic logic [BURST_W-1:0] eff_burst(input logic [BURST_W-1:0] bc);
    return (bc == '0) ? BURST_W'(1) : (bc > BURST_W'(MAX_BURST)) ? BURST_W'(MAX_BURST) : bc;
  endfunction
endpackage

// File: rtl/nios_system_mem_rr_arbiter.sv
// nios_system_mem_rr_arbiter: 2-way round-robin grant with last-grant memory
module nios_system_mem_rr_arbiter (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] grant
);
  logic r_last_grant;
  logic w_pick1;
  // port 1 wins alone, or on a tie when port 0 was served last
  always_comb begin
    w_pick1 = req[1] & (~req[0] | ~r_last_grant);
    grant   = enable ? {w_pick1, req[0] & ~w_pick1} : 2'b00;
  end
  // remember the winner so the next tie goes the other way
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_last_grant <= 1'b1;
    else if (enable && (|req)) r_last_grant <= w_pick1;
endmodule

// File: rtl/nios_system_main_memory_arbiter.sv
// nios_system_main_memory_arbiter: CPU/DMA arbiter and burst sequencer for the main memory
module nios_system_main_memory_arbiter
  import nios_system_mem_pkg::*;
#(
  parameter int ADDR_W    = MEM_ADDR_W,
  parameter int DATA_W    = MEM_DATA_W,
  parameter int DEPTH     = MEM_DEPTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [3:0]        m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [3:0]        m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic [4:0]        m1_burstcount,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              addr_err
);
  state_t            r_state, w_next;
  logic [1:0]        w_req, w_grant;
  logic              w_idle;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [4:0]        r_cnt, w_cnt;
  logic [3:0]        r_be, w_be;
  logic [DATA_W-1:0] w_wd;
  logic              w_issue, w_we, w_oor;
  port_t             w_port, r_tag;
  logic              r_rv, r_oor;
  logic [DATA_W-1:0] r_rd0, r_rd1, w_ret;

  assign w_req  = {m1_read | m1_write, m0_read | m0_write};
  assign w_idle = reset_n && (r_state == IDLE);
  assign w_cnt  = eff_burst(m1_burstcount);

  nios_system_mem_rr_arbiter u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (w_req),
    .enable  (w_idle),
    .grant   (w_grant)
  );

  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;

  // a multi-beat DMA grant opens a burst; the last issued beat closes it
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE)
      w_next = (w_grant[1] && w_cnt > 5'd1) ? (m1_read ? RD_BURST : WR_BURST) : IDLE;
    else if (w_issue && r_cnt == 5'd1)
      w_next = IDLE;
  end

  // request mux: the single beat, if any, presented to memory this cycle
  always_comb begin
    w_issue = 1'b0;
    w_we    = 1'b0;
    w_port  = PORT_CPU;
    w_addr  = '0;
    w_be    = '0;
    w_wd    = '0;
    if (w_grant[0]) begin
      w_issue = 1'b1;
      w_we    = m0_write;
      w_addr  = m0_address;
      w_be    = m0_byteenable;
      w_wd    = m0_writedata;
    end else if (w_grant[1]) begin
      w_issue = 1'b1;
      w_we    = m1_write;
      w_port  = PORT_DMA;
      w_addr  = m1_address;
      w_be    = m1_byteenable;
      w_wd    = m1_writedata;
    end else if (reset_n && r_state == RD_BURST) begin
      w_issue = 1'b1;
      w_port  = PORT_DMA;
      w_addr  = r_addr;
      w_be    = r_be;
    end else if (reset_n && r_state == WR_BURST && m1_write) begin
      w_issue = 1'b1;
      w_we    = 1'b1;
      w_port  = PORT_DMA;
      w_addr  = r_addr;
      w_be    = m1_byteenable;
      w_wd    = m1_writedata;
    end
  end

  assign w_oor          = w_addr >= ADDR_W'(DEPTH);
  assign mem_address    = w_addr;
  assign mem_byteenable = w_be;
  assign mem_writedata  = w_wd;
  assign mem_chipselect = w_issue & ~w_oor;
  assign mem_write      = w_issue & w_we & ~w_oor;
  assign mem_clken      = 1'b1;
  assign addr_err       = w_issue & w_oor;
  assign m0_waitrequest = ~w_grant[0];
  assign m1_waitrequest = ~(w_grant[1] | (reset_n & (r_state == WR_BURST) & m1_write));

  // burst beat and address counters; address wraps at the port width
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_cnt  <= '0;
      r_addr <= '0;
      r_be   <= '0;
    end else if (w_grant[1] && w_cnt > 5'd1) begin
      r_cnt  <= w_cnt - 5'd1;
      r_addr <= m1_address + ADDR_W'(1);
      r_be   <= m1_byteenable;
    end else if (r_state != IDLE && w_issue) begin
      r_cnt  <= r_cnt - 5'd1;
      r_addr <= r_addr + ADDR_W'(1);
    end

  // tag each issued read so its data returns to the right port; hold last data per port
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_rv  <= 1'b0;
      r_tag <= PORT_CPU;
      r_oor <= 1'b0;
      r_rd0 <= '0;
      r_rd1 <= '0;
    end else begin
      r_rv  <= w_issue & ~w_we;
      r_tag <= w_port;
      r_oor <= w_oor;
      r_rd0 <= m0_readdata;
      r_rd1 <= m1_readdata;
    end

  assign w_ret            = r_oor ? '0 : mem_readdata;
  assign m0_readdatavalid = r_rv & (r_tag == PORT_CPU);
  assign m1_readdatavalid = r_rv & (r_tag == PORT_DMA);
  assign m0_readdata      = m0_readdatavalid ? w_ret : r_rd0;
  assign m1_readdata      = m1_readdatavalid ? w_ret : r_rd1;
endmodule

// File: tb/tb_nios_system_main_memory_arbiter.sv
// tb_nios_system_main_memory_arbiter: directed vector and sequence checks for the memory arbiter
module tb_nios_system_main_memory_arbiter;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic [16:0] m0_address = '0, m1_address = '0, mem_address;
  logic [3:0]  m0_byteenable = '0, m1_byteenable = '0, mem_byteenable;
  logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [31:0] m0_writedata = '0, m1_writedata = '0, mem_writedata, mem_readdata = '0;
  logic [31:0] m0_readdata, m1_readdata;
  logic [4:0]  m1_burstcount = 5'd1;
  logic        m0_waitrequest, m0_readdatavalid, m1_waitrequest, m1_readdatavalid;
  logic        mem_chipselect, mem_write, mem_clken, addr_err;
  int tests = 0, fails = 0, wr_cnt = 0;
  logic [31:0] mem [int];

  nios_system_main_memory_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_burstcount(m1_burstcount), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fill(int a);
    return 32'hA500_0000 ^ 32'(a);
  endfunction

  function automatic logic [31:0] rdm(int a);
    return mem.exists(a) ? mem[a] : fill(a);
  endfunction

  // one-cycle-latency memory with byte enables
  always @(posedge clk) begin
    logic [31:0] w;
    int a;
    a = int'(mem_address);
    if (mem_chipselect && mem_write) begin
      w = rdm(a);
      for (int b = 0; b < 4; b++) if (mem_byteenable[b]) w[8*b +: 8] = mem_writedata[8*b +: 8];
      mem[a] = w;
      wr_cnt++;
    end else if (mem_chipselect) mem_readdata <= rdm(a);
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  typedef struct {
    logic m0r, m0w; logic [16:0] a0; logic [31:0] d0; logic [3:0] be0;
    logic m1r, m1w; logic [16:0] a1; logic [31:0] d1; logic [3:0] be1; logic [4:0] bc;
    logic w0, w1, cs, we, err, rv0, rv1; logic [16:0] ma; logic [31:0] rd0, rd1;
  } vec_t;

  localparam logic H = 1'b1, L = 1'b0;
  localparam int NV = 14;
  vec_t v [NV];

  initial begin
    v[0]  = '{L,L,17'h0,32'h0,4'h0,        L,L,17'h0,32'h0,4'h0,5'd1, H,H,L,L,L,L,L, 17'h0,     32'h0,        32'h0};
    v[1]  = '{L,H,17'h10,32'hDEADBEEF,4'hF, L,L,17'h0,32'h0,4'h0,5'd1, L,H,H,H,L,L,L, 17'h10,    32'h0,        32'h0};
    v[2]  = '{H,L,17'h10,32'h0,4'hF,       L,L,17'h0,32'h0,4'h0,5'd1, L,H,H,L,L,L,L, 17'h10,    32'h0,        32'h0};
    v[3]  = '{L,L,17'h0,32'h0,4'h0,        H,L,17'h30,32'h0,4'hF,5'd1, H,L,H,L,L,H,L, 17'h30,   32'hDEADBEEF, 32'h0};
    v[4]  = '{H,L,17'h10,32'h0,4'hF,       H,L,17'h21,32'h0,4'hF,5'd1, L,H,H,L,L,L,H, 17'h10,   32'hDEADBEEF, 32'hA5000030};
    v[5]  = '{H,L,17'h11,32'h0,4'hF,       H,L,17'h21,32'h0,4'hF,5'd1, H,L,H,L,L,H,L, 17'h21,   32'hDEADBEEF, 32'hA5000030};
    v[6]  = '{H,L,17'h11,32'h0,4'hF,       H,L,17'h22,32'h0,4'hF,5'd1, L,H,H,L,L,L,H, 17'h11,   32'hDEADBEEF, 32'hA5000021};
    v[7]  = '{H,L,17'h12,32'h0,4'hF,       H,L,17'h22,32'h0,4'hF,5'd1, H,L,H,L,L,H,L, 17'h22,   32'hA5000011, 32'hA5000021};
    v[8]  = '{L,L,17'h0,32'h0,4'h0,        L,L,17'h0,32'h0,4'h0,5'd1, H,H,L,L,L,L,H, 17'h0,     32'hA5000011, 32'hA5000022};
    v[9]  = '{H,L,17'h12C00,32'h0,4'hF,    L,L,17'h0,32'h0,4'h0,5'd1, L,H,L,L,H,L,L, 17'h12C00, 32'hA5000011, 32'hA5000022};
    v[10] = '{L,L,17'h0,32'h0,4'h0,        L,L,17'h0,32'h0,4'h0,5'd1, H,H,L,L,L,H,L, 17'h0,     32'h0,        32'hA5000022};
    v[11] = '{L,L,17'h0,32'h0,4'h0,        L,H,17'h40,32'h12345678,4'h3,5'd0, H,L,H,H,L,L,L, 17'h40, 32'h0,     32'hA5000022};
    v[12] = '{H,L,17'h40,32'h0,4'hF,       L,L,17'h0,32'h0,4'h0,5'd1, L,H,H,L,L,L,L, 17'h40,    32'h0,        32'hA5000022};
    v[13] = '{L,L,17'h0,32'h0,4'h0,        L,L,17'h0,32'h0,4'h0,5'd1, H,H,L,L,L,H,L, 17'h0,     32'hA5005678, 32'hA5000022};

    m0_read = 1'b1;
    m1_read = 1'b1;
    repeat (2) @(posedge clk);
    smp();
    chk("rst w0", m0_waitrequest, 1);
    chk("rst w1", m1_waitrequest, 1);
    chk("rst cs", mem_chipselect, 0);
    chk("rst ma", mem_address, 0);
    chk("rst rv", {m0_readdatavalid, m1_readdatavalid}, 0);
    chk("rst rd0", m0_readdata, 0);
    chk("rst rd1", m1_readdata, 0);
    chk("rst err", addr_err, 0);
    m0_read = 1'b0;
    m1_read = 1'b0;
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      step();
      m0_read = v[i].m0r; m0_write = v[i].m0w; m0_address = v[i].a0; m0_writedata = v[i].d0;
      m0_byteenable = v[i].be0;
      m1_read = v[i].m1r; m1_write = v[i].m1w; m1_address = v[i].a1; m1_writedata = v[i].d1;
      m1_byteenable = v[i].be1; m1_burstcount = v[i].bc;
      smp();
      chk($sformatf("v%0d w0", i), m0_waitrequest, v[i].w0);
      chk($sformatf("v%0d w1", i), m1_waitrequest, v[i].w1);
      chk($sformatf("v%0d cs", i), mem_chipselect, v[i].cs);
      chk($sformatf("v%0d we", i), mem_write, v[i].we);
      chk($sformatf("v%0d err", i), addr_err, v[i].err);
      chk($sformatf("v%0d rv0", i), m0_readdatavalid, v[i].rv0);
      chk($sformatf("v%0d rv1", i), m1_readdatavalid, v[i].rv1);
      chk($sformatf("v%0d ma", i), mem_address, v[i].ma);
      chk($sformatf("v%0d rd0", i), m0_readdata, v[i].rd0);
      chk($sformatf("v%0d rd1", i), m1_readdata, v[i].rd1);
    end

    step();
    m0_read = 1'b1; m0_write = 1'b0; m0_address = 17'h10;
    m1_read = 1'b1; m1_write = 1'b0; m1_address = 17'h100; m1_burstcount = 5'd16; m1_byteenable = 4'hF;
    for (int k = 0; k <= 16; k++) begin
      smp();
      if (k < 16) begin
        chk($sformatf("rb%0d ma", k), mem_address, 32'h100 + 32'(k));
        chk($sformatf("rb%0d w0", k), m0_waitrequest, 1);
        chk($sformatf("rb%0d w1", k), m1_waitrequest, (k == 0) ? 0 : 1);
        chk($sformatf("rb%0d cs", k), mem_chipselect, 1);
      end else begin
        chk("rb16 w0", m0_waitrequest, 0);
        chk("rb16 ma", mem_address, 32'h10);
      end
      if (k > 0) begin
        chk($sformatf("rb%0d rv1", k), m1_readdatavalid, 1);
        chk($sformatf("rb%0d rd1", k), m1_readdata, fill(32'h100 + k - 1));
      end
      step();
      if (k == 0) m1_read = 1'b0;
    end
    m0_read = 1'b0;
    smp();
    chk("rb end rv0", m0_readdatavalid, 1);
    chk("rb end rd0", m0_readdata, 32'hDEADBEEF);

    begin
      logic [6:0] wseq;
      int beat, wr0;
      wseq = 7'b0110011;
      beat = 0;
      wr0 = wr_cnt;
      step();
      m0_read = 1'b1; m0_address = 17'h10;
      m1_address = 17'h200; m1_burstcount = 5'd4; m1_byteenable = 4'hF;
      for (int k = 0; k < 7; k++) begin
        m1_write = wseq[k];
        m1_writedata = 32'hC0DE_0000 + 32'(beat);
        smp();
        if (k < 6) begin
          chk($sformatf("wb%0d w0", k), m0_waitrequest, 1);
          chk($sformatf("wb%0d w1", k), m1_waitrequest, wseq[k] ? 0 : 1);
          chk($sformatf("wb%0d cs", k), mem_chipselect, wseq[k]);
          if (wseq[k]) chk($sformatf("wb%0d ma", k), mem_address, 32'h200 + 32'(beat));
        end else chk("wb6 w0", m0_waitrequest, 0);
        if (wseq[k]) beat++;
        step();
      end
      m0_read = 1'b0;
      chk("wb count", wr_cnt - wr0, 4);
      for (int j = 0; j < 4; j++) chk($sformatf("wb mem%0d", j), rdm(32'h200 + j), 32'hC0DE_0000 + 32'(j));
    end

    begin
      int errs;
      errs = 0;
      m1_read = 1'b1; m1_address = 17'd76798; m1_burstcount = 5'd4;
      for (int k = 0; k <= 4; k++) begin
        smp();
        if (addr_err) errs++;
        if (k < 4) begin
          chk($sformatf("oor%0d ma", k), mem_address, 32'd76798 + 32'(k));
          chk($sformatf("oor%0d cs", k), mem_chipselect, (k < 2) ? 1 : 0);
          chk($sformatf("oor%0d err", k), addr_err, (k >= 2) ? 1 : 0);
        end
        if (k > 0) begin
          chk($sformatf("oor%0d rv1", k), m1_readdatavalid, 1);
          chk($sformatf("oor%0d rd1", k), m1_readdata, (k <= 2) ? fill(76798 + k - 1) : 32'h0);
        end
        step();
        if (k == 0) m1_read = 1'b0;
      end
      chk("oor err count", errs, 2);
    end

    m1_read = 1'b1; m1_address = 17'h300; m1_burstcount = 5'd16;
    smp();
    step();
    m1_read = 1'b0;
    smp();
    step();
    chk("rst mid ma", mem_address, 32'h302);
    reset_n = 1'b0;
    #1;
    chk("rst mid w0", m0_waitrequest, 1);
    chk("rst mid w1", m1_waitrequest, 1);
    chk("rst mid cs", mem_chipselect, 0);
    chk("rst mid ma0", mem_address, 0);
    chk("rst mid rv", {m0_readdatavalid, m1_readdatavalid}, 0);
    chk("rst mid rd1", m1_readdata, 0);
    smp();
    step();
    smp();
    chk("rst hold rv", {m0_readdatavalid, m1_readdatavalid}, 0);
    reset_n = 1'b1;
    step();
    m0_read = 1'b1; m0_address = 17'h10;
    m1_read = 1'b1; m1_address = 17'h31; m1_burstcount = 5'd1;
    smp();
    chk("post rst w0", m0_waitrequest, 0);
    chk("post rst w1", m1_waitrequest, 1);
    chk("post rst ma", mem_address, 32'h10);
    step();
    m0_read = 1'b0;
    smp();
    chk("post rst2 w1", m1_waitrequest, 0);
    chk("post rst2 rd0", m0_readdata, 32'hDEADBEEF);
    step();
    m1_read = 1'b0;
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
